// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared constants and helpers for the stream multiplexer slice.
//   MODE_FIXED / MODE_RR : arbitration mode selectors for the MODE parameter
//   clog2()              : ceiling log2, used to size channel indices
//   chan_width()         : index width, never narrower than one bit
package stream_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // A single-channel mux still needs a one-bit index port.
  function automatic int chan_width(input int channels);
    return (clog2(channels) > 1) ? clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational arbiter selecting one requester per cycle.
//   req       : in  CHANNELS  request vector
//   ptr       : in  CW        last granted index (round-robin mode only)
//   grant     : out CHANNELS  one-hot grant, zero when nothing requests
//   grant_idx : out CW        encoded index of the granted channel
// MODE_FIXED gives the lowest requesting index; MODE_RR searches upward
// from ptr+1 and wraps back to ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_FIXED,
  localparam int CW       = chan_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [CW-1:0]       grant_idx
);

  logic          found;
  logic [CW-1:0] start;

  // The wrapped search is split into two ascending passes: first the
  // channels above the start point, then those at or below it. Fixed
  // priority is the same search with the start pinned to the top channel,
  // which leaves only the second pass and therefore lowest-index-wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    start     = (MODE == MODE_RR) ? ptr : CW'(CHANNELS - 1);
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && req[i] && (CW'(i) > start)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = CW'(i);
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && req[i] && (CW'(i) <= start)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = CW'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux
// N-to-1 valid/ready stream multiplexer with a registered output stage.
//   clk       : in  1               rising-edge clock
//   rst_n     : in  1               asynchronous active-low reset
//   in_valid  : in  CHANNELS        per-channel beat available
//   in_data   : in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_ready  : out CHANNELS        per-channel beat accepted this cycle
//   out_valid : out 1               registered beat present
//   out_data  : out WIDTH           registered beat data
//   out_chan  : out CW              source channel of the current beat
//   out_ready : in  1               consumer accepts the beat
// The output register reloads whenever it is empty or being drained, so
// back-to-back beats flow at one per cycle with no bubbles.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_FIXED,
  localparam int CW       = chan_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  input  logic                      out_ready
);

  logic                load;
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic [CW-1:0]       ptr;
  logic [WIDTH-1:0]    sel_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE)
  ) u_arbiter (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load = !out_valid || out_ready;

  // The empty output register would otherwise advertise ready while reset
  // is held, so acceptance is also gated by rst_n.
  assign in_ready = (rst_n && load) ? grant : '0;

  // grant is one-hot, so an AND-OR mux picks the winning channel's data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // When the slot frees up with no requester, only the valid flag drops;
  // data and channel keep the last beat. ptr moves only on an accepted
  // beat and starts at the top channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= CW'(CHANNELS - 1);
    end else if (load) begin
      if (|grant) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= grant_idx;
        if (MODE == MODE_RR) begin
          ptr <= grant_idx;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-to-1 stream multiplexer with registered output and valid/ready handshakes on every channel. It is the successor to the combinational 2:1 32-bit `mux`. It arbitrates between `CHANNELS` producers using fixed-priority or round-robin mode, transfers one beat per cycle at full throughput, and holds the output stable under backpressure. It sits between multiple datapath producers and a single shared consumer, for example a register-file write port or a bus master.

## Interface
- `WIDTH`, 32, data width in bits (≥1)
- `CHANNELS`, 4, number of input channels (≥1)
- `MODE`, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  CHANNELS  per-channel beat available
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_ready`  out  CHANNELS  per-channel beat accepted this cycle
- `out_valid`  out  1  registered output beat present
- `out_data`  out  WIDTH  registered output data
- `out_chan`  out  CW  source channel of current beat, CW = max(1, clog2(CHANNELS))
- `out_ready`  in  1  consumer accepts beat

## Operation
- `load` = `!out_valid || out_ready`. The output register can accept a new beat this cycle.
- `grant` is a one-hot, combinational function of `in_valid` and the round-robin pointer `ptr`. `grant` is zero when no input is valid.
- `in_ready[i]` = `grant[i] && load`. At most one bit is set per cycle.
- When `load` is true:
  - If any `in_valid` is set: `out_data` ← data of the granted channel, `out_chan` ← its index, `out_valid` ← 1.
  - Otherwise `out_valid` ← 0, and `out_data`/`out_chan` hold their values.
- When `load` is false, all output registers hold.
- Fixed-priority mode: the lowest-index valid channel wins. `ptr` is unused.
- Round-robin mode: the search starts at `ptr+1` mod CHANNELS and wraps. On every accepted input beat, `ptr` ← granted index. `ptr` does not change when no beat is accepted.
- Producers must keep `in_valid`/`in_data` stable until `in_ready`. The block does not check this.
- `CHANNELS`=1 degenerates to a 1-entry pipeline register. `out_chan` is then constant 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=CHANNELS-1, so channel 0 has first priority.
- During reset, `in_ready`=0.
- Latency: a beat accepted on edge n appears on `out_*` immediately after edge n. Minimum input-to-output delay is one cycle.
- Throughput: one beat per cycle while `out_ready`=1 and inputs are valid. There are no bubbles on back-to-back transfers.
- Simultaneous output accept and new load in the same cycle: the new beat replaces the old one, and there is no gap.
- Backpressure (`out_valid`=1, `out_ready`=0): `out_data`/`out_chan` hold, all `in_ready`=0, and `ptr` holds.
- Reset asserted mid-transfer: the pending output beat is discarded and `ptr` returns to CHANNELS-1 asynchronously. The first edge after deassertion behaves as the first cycle out of reset.
- `out_ready` may be asserted while `out_valid`=0; this has no effect beyond allowing a load.
- The only combinational paths are `in_valid`/`out_ready` → `in_ready`. There are no combinational paths to `out_*`.

## Structure
- Package `stream_mux_pkg`:
  - Mode constants `MODE_FIXED`=0 and `MODE_RR`=1.
  - A `clog2` helper function for the `out_chan`/`ptr` width.
- Sub-module `rr_arbiter`:
  - Parameters: `CHANNELS`, `MODE`.
  - Inputs: `req`, `ptr`. Output: one-hot `grant` plus encoded `grant_idx`.
  - Purely combinational. `stream_mux` owns the `ptr` register and the output registers.

## Test plan
- Reset: hold `rst_n`=0 with all `in_valid`=1. Expect `out_valid`=0, `out_data`=0, `in_ready`=0. After release, the first grant goes to channel 0 in both modes.
- Fixed priority, WIDTH=32, CHANNELS=4:
  - Stimulus: ch0=AAAAAAAA, ch1=55555555, both valid, `out_ready`=1.
  - Expect ch0 beats every cycle and ch1 starved.
  - Drop ch0: the next cycle `out_data`=55555555, `out_chan`=1.
- Round-robin, all four channels valid with data 0,1,2,3 and `out_ready`=1: expect `out_chan` to sequence 0,1,2,3,0,… with one beat per cycle.
- Backpressure:
  - Stimulus: load ch2=A5A5A5A5, then `out_ready`=0 for 5 cycles while ch3=DDDDDDDD is valid.
  - Expect the output to hold A5A5A5A5/2 and `in_ready`=0 throughout.
  - Raise `out_ready`: the next beat is DDDDDDDD/3 with no bubble.
- Drain: a single beat FFFFFFFF on ch1, then no valid inputs. Expect `out_valid` to fall one cycle after acceptance and `out_data` to remain FFFFFFFF.
- Async reset mid-stream: assert `rst_n`=0 between edges while `out_valid`=1. Expect the outputs to clear immediately, with no clock edge needed, and round-robin order to restart at channel 0.
